// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared data-plane definitions for the CNN datapath (line buffer, conv,
// relu and pooling stages).
//   CNN_ACC_WIDTH      : width of the signed accumulator / activation word
//   CNN_IMG_WIDTH      : input image side length
//   CNN_CONV_OUT_WIDTH : side length of the valid-convolution output map
//   CNN_POOL_OUT_WIDTH : side length after 2x2 stride-2 pooling
//   cnn_acc_t          : signed activation word
// -----------------------------------------------------------------------------
package cnn_pkg;

   localparam int CNN_ACC_WIDTH      = 32;
   localparam int CNN_IMG_WIDTH      = 28;
   localparam int CNN_CONV_OUT_WIDTH = 26;
   localparam int CNN_POOL_OUT_WIDTH = 13;

   typedef logic signed [31:0] cnn_acc_t;

endpackage : cnn_pkg

// File: rtl/pool2x2_rowbuf.sv
// -----------------------------------------------------------------------------
// pool2x2_rowbuf
// Half-row buffer for the 2x2 max-pool stage. Holds one horizontal pair
// maximum per pooled column, written on even input rows and read back on the
// following odd row. Flop-based storage without reset.
// Ports:
//   clk_i      in   clock
//   wr_en_i    in   write strobe
//   wr_addr_i  in   write address (pooled column)
//   wr_data_i  in   signed pair maximum to store
//   rd_addr_i  in   read address (pooled column)
//   rd_data_o  out  signed stored value, combinational read
// -----------------------------------------------------------------------------
module pool2x2_rowbuf
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = CNN_ACC_WIDTH,
   parameter int DEPTH      = CNN_POOL_OUT_WIDTH,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                         clk_i,
   input  logic                         wr_en_i,
   input  logic        [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic signed [DATA_WIDTH-1:0] wr_data_i,
   input  logic        [ADDR_WIDTH-1:0] rd_addr_i,
   output logic signed [DATA_WIDTH-1:0] rd_data_o
);

   logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Decoded per-entry write; addresses beyond DEPTH-1 never match.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_en_i && (wr_addr_i == ADDR_WIDTH'(i))) begin
            mem_q[i] <= wr_data_i;
         end
      end
   end

   // Mux-based read so an out-of-range address returns zero instead of
   // indexing past the array.
   always_comb begin
      rd_data_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_addr_i == ADDR_WIDTH'(i)) begin
            rd_data_o = mem_q[i];
         end
      end
   end

endmodule : pool2x2_rowbuf

// File: rtl/pool2x2_stream.sv
// -----------------------------------------------------------------------------
// pool2x2_stream
// Streaming 2x2 stride-2 max-pool. Consumes a raster-order signed feature map
// over ready/valid and emits the pooled map in raster order. Horizontal pairs
// are reduced in pair_q; even rows park the pair max in a half-row buffer and
// odd rows combine it with their own pair max into the output register.
// Ports:
//   clk_i        in   clock
//   rst_i        in   synchronous active-high reset
//   clear_i      in   synchronous frame abort (same effect as reset)
//   in_data_i    in   signed input sample
//   in_valid_i   in   input sample valid
//   in_ready_o   out  stage accepts input
//   out_data_o   out  signed pooled sample
//   out_valid_o  out  pooled sample valid
//   out_ready_i  in   downstream accepts
//   out_last_o   out  final pooled sample of the frame
//   frame_done_o out  one-cycle pulse after the frame's last input is accepted
// -----------------------------------------------------------------------------
module pool2x2_stream
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = CNN_ACC_WIDTH,
   parameter int IN_WIDTH   = CNN_CONV_OUT_WIDTH,
   parameter int IN_HEIGHT  = CNN_CONV_OUT_WIDTH
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         clear_i,
   input  logic signed [DATA_WIDTH-1:0] in_data_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   output logic signed [DATA_WIDTH-1:0] out_data_o,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic                         out_last_o,
   output logic                         frame_done_o
);

   localparam int OUT_WIDTH  = IN_WIDTH / 2;
   localparam int OUT_HEIGHT = IN_HEIGHT / 2;
   localparam int CW         = $clog2(IN_WIDTH);
   localparam int RW         = $clog2(IN_HEIGHT);

   localparam logic [CW-1:0] COL_MAX      = CW'(IN_WIDTH - 1);
   localparam logic [RW-1:0] ROW_MAX      = RW'(IN_HEIGHT - 1);
   localparam logic [CW-1:0] POOL_COL_MAX = CW'(2 * OUT_WIDTH - 1);
   localparam logic [RW-1:0] POOL_ROW_MAX = RW'(2 * OUT_HEIGHT - 1);

   function automatic logic signed [DATA_WIDTH-1:0] smax(
      input logic signed [DATA_WIDTH-1:0] a,
      input logic signed [DATA_WIDTH-1:0] b
   );
      return (a > b) ? a : b;
   endfunction

   logic        [CW-1:0]         col_q, col_d;
   logic        [RW-1:0]         row_q, row_d;
   logic signed [DATA_WIDTH-1:0] pair_q, pair_d;
   logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                         out_valid_q, out_valid_d;
   logic                         out_last_q, out_last_d;
   logic                         frame_done_q, frame_done_d;

   logic                         accept;
   logic                         xfer;
   logic                         col_last;
   logic                         row_last;
   logic                         rb_wr_en;
   logic                         emit;
   logic signed [DATA_WIDTH-1:0] pair_max;
   logic signed [DATA_WIDTH-1:0] rb_rd_data;

   // Single output register: accept whenever it is empty or draining now.
   assign in_ready_o = !out_valid_q || out_ready_i;
   assign accept     = in_valid_i && in_ready_o;
   assign xfer       = out_valid_q && out_ready_i;

   assign col_last = (col_q == COL_MAX);
   assign row_last = (row_q == ROW_MAX);
   assign pair_max = smax(pair_q, in_data_i);

   // A trailing odd column/row always lands on an even index, so gating on
   // the LSBs alone drops it. A trailing-row rowbuf write is harmless: the
   // entry is rewritten by row 0 of the next frame before it is read.
   assign rb_wr_en = accept && col_q[0] && !row_q[0];
   assign emit     = accept && col_q[0] && row_q[0];

   pool2x2_rowbuf #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (OUT_WIDTH),
      .ADDR_WIDTH (CW)
   ) u_rowbuf (
      .clk_i     (clk_i),
      .wr_en_i   (rb_wr_en),
      .wr_addr_i (col_q >> 1),
      .wr_data_i (pair_max),
      .rd_addr_i (col_q >> 1),
      .rd_data_o (rb_rd_data)
   );

   // ---- next-state: counters, pair register, output register ----
   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      pair_d       = pair_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      frame_done_d = 1'b0;

      if (xfer) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      if (accept) begin
         if (!col_q[0]) begin
            pair_d = in_data_i;
         end

         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end

         // A load in the same cycle as a transfer overwrites without a bubble.
         if (emit) begin
            out_data_d  = smax(pair_max, rb_rd_data);
            out_valid_d = 1'b1;
            out_last_d  = (row_q == POOL_ROW_MAX) && (col_q == POOL_COL_MAX);
         end

         frame_done_d = col_last && row_last;
      end

      if (clear_i) begin
         col_d        = '0;
         row_d        = '0;
         out_data_d   = '0;
         out_valid_d  = 1'b0;
         out_last_d   = 1'b0;
         frame_done_d = 1'b0;
      end
   end

   // ---- register stage ----
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         col_q        <= '0;
         row_q        <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Pair register is pure data; it is always written before being read.
   always_ff @(posedge clk_i) begin
      pair_q <= pair_d;
   end

   assign out_data_o   = out_data_q;
   assign out_valid_o  = out_valid_q;
   assign out_last_o   = out_last_q;
   assign frame_done_o = frame_done_q;

endmodule : pool2x2_stream
